regs_ctrl: RTL and testbench
============================

Name: regs_ctrl

Overview:
Controller for the 32x32 register file's single write port.
- Arbitrates that port between three writers: ALU/pipeline writeback, the load unit and the debug port.
- Keeps a per-register scoreboard of outstanding loads and stalls decode on hazards against it.
- After reset, sequences a clear of x1..x31 before releasing the pipeline.
- Sits between the pipeline/LSU/debug logic and the register file's i_we/i_addr_wr/i_dat_wr inputs.

Parameters:
XLEN, 32, data width of the write port
INIT_CLEAR, 1, 1 = run the post-reset clear sequence; 0 = enter RUN directly after reset

Ports:
i_clk  in  1  clock; all state on the rising edge
i_rst  in  1  synchronous, active-high reset
i_alu_we  in  1  pipeline writeback valid; must never be stalled
i_alu_rd  in  5  pipeline writeback destination
i_alu_dat  in  XLEN  pipeline writeback data
i_ld_valid  in  1  load result valid
i_ld_rd  in  5  load destination
i_ld_dat  in  XLEN  load data
o_ld_ready  out  1  load result accepted this cycle
i_dbg_valid  in  1  debug write request
i_dbg_rd  in  5  debug destination
i_dbg_dat  in  XLEN  debug data
o_dbg_ready  out  1  debug write accepted this cycle
i_ld_issue  in  1  load issued this cycle; sets the scoreboard bit for i_ld_issue_rd
i_ld_issue_rd  in  5  issued load destination
i_dec_valid  in  1  decode stage holds a valid instruction
i_dec_rs1  in  5  decode source register 1
i_dec_rs2  in  5  decode source register 2
i_dec_rd  in  5  decode destination register
o_stall  out  1  hold decode
o_busy  out  1  clear sequence in progress
o_we  out  1  register file write enable
o_addr_wr  out  5  register file write address
o_dat_wr  out  XLEN  register file write data

Behaviour:
State machine: INIT, RUN.
- Reset enters INIT if INIT_CLEAR=1, otherwise RUN.
- Reset clears pending[31:0] and sets the clear counter to 1.
- Outputs during the reset cycle: o_we=0, o_ld_ready=0, o_dbg_ready=0, o_busy=INIT_CLEAR, o_stall=INIT_CLEAR.

INIT:
- Each cycle drives o_we=1, o_addr_wr=counter, o_dat_wr=0, then increments the counter.
- After writing address 31, moves to RUN.
- INIT is exactly 31 cycles.
- o_busy=1 and o_stall=1 throughout; both ready outputs are 0; all requests are ignored.
- Reset asserted mid-INIT restarts the sequence at counter 1.

RUN, write port priority (all combinational, zero latency):
- Priority: ALU > load > debug.
- i_alu_we=1: write the ALU data; o_ld_ready=0, o_dbg_ready=0.
- Otherwise i_ld_valid=1: write the load data; o_ld_ready=1.
- Otherwise i_dbg_valid=1: write the debug data; o_dbg_ready=1.
- A ready output is asserted only in a cycle where the matching valid is 1.
- Requesters hold valid and payload stable until ready.

Writes to x0:
- The handshake completes normally, but o_we=0.
- o_addr_wr and o_dat_wr still carry the payload.

Scoreboard:
- On a clock edge with i_ld_issue=1 and i_ld_issue_rd!=0, set pending[rd].
- On a clock edge with an accepted load (o_ld_ready=1), clear pending[i_ld_rd].
- If issue and completion target the same register on the same edge, set wins.
- pending[0] is always 0.

Stall rule:
- o_stall = busy OR (i_dec_valid AND (pending[rs1] OR pending[rs2] OR pending[rd])).
- The rd term covers WAW.
- Stall lifts the cycle after the load write is accepted, because the register file read is registered.
- o_stall is combinational and has no dependency on o_ld_ready (no loop).

Debug and load may starve under continuous ALU writes; this is acceptable, since the pipeline stalls on pending loads.

Test Plan:
- Reset with INIT_CLEAR=1, hold idle → o_we=1 for 31 consecutive cycles, addresses 1..31, data 0; o_busy=1 for exactly those cycles, then 0.
- In RUN: i_alu_we=1 (rd=5, 0xAAAA0000), i_ld_valid=1 (rd=6, 0x1234), i_dbg_valid=1 (rd=7, 0x55) for 3 cycles, ALU dropping after cycle 1 → write order: rd5/0xAAAA0000, rd6/0x1234 with o_ld_ready=1, rd7/0x55 with o_dbg_ready=1.
- i_ld_issue rd=10, then decode rs1=10 → o_stall=1 until the cycle after the load (rd=10, 0xDEAD) is accepted; then o_stall=0 and pending[10]=0.
- Same edge: i_ld_issue rd=3 and load completion rd=3 → pending[3] stays 1 and decode of rs2=3 still stalls.
- Load to rd=0 with data 0xFFFF, and i_ld_issue rd=0 → o_ld_ready=1, o_we=0, no stall on rs1=0.
- i_rst pulsed at INIT cycle 12 → sequence restarts at address 1 and runs a full 31 cycles.

Source files
------------

// File: rtl/regs_ctrl.sv
// Register file write-port controller.
// Three writers (pipeline writeback, load unit, debug port) share the one
// write port under fixed priority. A per-register scoreboard of outstanding
// loads drives the decode stall. After reset an optional sequence clears
// x1..x31 before the pipeline is let go.
module regs_ctrl #(
    parameter int XLEN       = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,

    // pipeline writeback: highest priority, never back-pressured
    input  logic            i_alu_we,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_dat,

    // load unit result
    input  logic            i_ld_valid,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_dat,
    output logic            o_ld_ready,

    // debug port write
    input  logic            i_dbg_valid,
    input  logic [4:0]      i_dbg_rd,
    input  logic [XLEN-1:0] i_dbg_dat,
    output logic            o_dbg_ready,

    // load issue marks the destination as outstanding
    input  logic            i_ld_issue,
    input  logic [4:0]      i_ld_issue_rd,

    // decode-stage hazard check
    input  logic            i_dec_valid,
    input  logic [4:0]      i_dec_rs1,
    input  logic [4:0]      i_dec_rs2,
    input  logic [4:0]      i_dec_rd,
    output logic            o_stall,
    output logic            o_busy,

    // register file write port
    output logic            o_we,
    output logic [4:0]      o_addr_wr,
    output logic [XLEN-1:0] o_dat_wr
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [4:0]      clr_cnt;
    logic [4:0]      clr_cnt_nx;
    logic [31:0]     pending;
    logic [31:0]     pending_nx;

    // Selected writer, before the x0 write suppression is applied.
    logic            wr_req;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_dat;

    logic            busy;
    logic            hazard;
    logic            issue_set;

    // State register, clear counter and outstanding-load scoreboard.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (INIT_CLEAR) begin
                state <= ST_INIT;
            end else begin
                state <= ST_RUN;
            end
            clr_cnt <= 5'd1;
            pending <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            pending <= pending_nx;
        end
    end

    // Next-state logic, clear sequencing and write-port arbitration.
    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nx    = state;
        clr_cnt_nx  = clr_cnt;
        busy        = 1'b0;
        wr_req      = 1'b0;
        wr_addr     = 5'd0;
        wr_dat      = '0;
        o_ld_ready  = 1'b0;
        o_dbg_ready = 1'b0;

        if (i_rst) begin
            // Reset cycle: nothing is written or accepted; decode is held
            // only when a clear sequence is about to run.
            busy = INIT_CLEAR;
        end else begin
            case (state)
                ST_INIT: begin
                    // Zero one register per cycle, x1 through x31. x0 is
                    // hardwired so it is skipped. Requests are ignored.
                    busy       = 1'b1;
                    wr_req     = 1'b1;
                    wr_addr    = clr_cnt;
                    wr_dat     = '0;
                    clr_cnt_nx = clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31) begin
                        state_nx = ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Fixed priority ALU > load > debug. The ALU has no
                    // ready: it always wins and the others simply wait.
                    if (i_alu_we) begin
                        wr_req  = 1'b1;
                        wr_addr = i_alu_rd;
                        wr_dat  = i_alu_dat;
                    end else if (i_ld_valid) begin
                        wr_req     = 1'b1;
                        wr_addr    = i_ld_rd;
                        wr_dat     = i_ld_dat;
                        o_ld_ready = 1'b1;
                    end else if (i_dbg_valid) begin
                        wr_req      = 1'b1;
                        wr_addr     = i_dbg_rd;
                        wr_dat      = i_dbg_dat;
                        o_dbg_ready = 1'b1;
                    end
                end

                default: begin
                    state_nx = ST_RUN;
                end
            endcase
        end
    end

    // Drive the register file port. Writes to x0 complete their handshake
    // but never assert the enable; address and data still show the payload.
    always_comb begin
        o_we      = wr_req && (wr_addr != 5'd0);
        o_addr_wr = wr_addr;
        o_dat_wr  = wr_dat;
        o_busy    = busy;
    end

    // Scoreboard update: an accepted load retires its destination, a new
    // issue marks its destination. Issue is applied last so that on a
    // same-register collision the newer load stays outstanding.
    always_comb begin
        issue_set  = i_ld_issue && (i_ld_issue_rd != 5'd0) &&
                     (state == ST_RUN) && !i_rst;
        pending_nx = pending;
        if (o_ld_ready) begin
            pending_nx[i_ld_rd] = 1'b0;
        end
        if (issue_set) begin
            pending_nx[i_ld_issue_rd] = 1'b1;
        end
        pending_nx[0] = 1'b0;
    end

    // Decode stall: built only from registered scoreboard state and decode
    // inputs, never from the handshake outputs, so no combinational loop.
    // The register file read is registered, so a register is usable the
    // cycle after its load is written, which is when its pending bit drops.
    always_comb begin
        hazard  = i_dec_valid && !i_rst &&
                  (pending[i_dec_rs1] || pending[i_dec_rs2] || pending[i_dec_rd]);
        o_stall = busy || hazard;
    end

endmodule

// File: tb/tb_regs_ctrl.sv
// Self-checking bench for regs_ctrl. Expected write-port transactions are
// queued as stimulus is applied and matched in order by a monitor that
// samples on the falling edge; each test task also checks stall/busy inline.
module tb_regs_ctrl;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] dat;
        logic            ld_rdy;
        logic            dbg_rdy;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_we;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_dat;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_dat;
    logic            ld_ready;
    logic            dbg_valid;
    logic [4:0]      dbg_rd;
    logic [XLEN-1:0] dbg_dat;
    logic            dbg_ready;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic            dec_valid;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            stall;
    logic            busy;
    logic            we;
    logic [4:0]      addr_wr;
    logic [XLEN-1:0] dat_wr;

    int  checks   = 0;
    int  failures = 0;
    wr_t sb[$];

    regs_ctrl #(.XLEN(XLEN), .INIT_CLEAR(1'b1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_we      (alu_we),
        .i_alu_rd      (alu_rd),
        .i_alu_dat     (alu_dat),
        .i_ld_valid    (ld_valid),
        .i_ld_rd       (ld_rd),
        .i_ld_dat      (ld_dat),
        .o_ld_ready    (ld_ready),
        .i_dbg_valid   (dbg_valid),
        .i_dbg_rd      (dbg_rd),
        .i_dbg_dat     (dbg_dat),
        .o_dbg_ready   (dbg_ready),
        .i_ld_issue    (ld_issue),
        .i_ld_issue_rd (ld_issue_rd),
        .i_dec_valid   (dec_valid),
        .i_dec_rs1     (dec_rs1),
        .i_dec_rs2     (dec_rs2),
        .i_dec_rd      (dec_rd),
        .o_stall       (stall),
        .o_busy        (busy),
        .o_we          (we),
        .o_addr_wr     (addr_wr),
        .o_dat_wr      (dat_wr)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write-port event (enable or a handshake)
    // must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        if (we === 1'b1 || ld_ready === 1'b1 || dbg_ready === 1'b1) begin
            got = '{we: we, addr: addr_wr, dat: dat_wr, ld_rdy: ld_ready, dbg_rdy: dbg_ready};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write t=%0t got we=%b addr=%0d dat=%h ldr=%b dbgr=%b",
                         $time, got.we, got.addr, got.dat, got.ld_rdy, got.dbg_rdy);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL write_order t=%0t got we=%b addr=%0d dat=%h ldr=%b dbgr=%b exp we=%b addr=%0d dat=%h ldr=%b dbgr=%b",
                             $time, got.we, got.addr, got.dat, got.ld_rdy, got.dbg_rdy,
                             exp.we, exp.addr, exp.dat, exp.ld_rdy, exp.dbg_rdy);
                end
            end
        end
    end

    task automatic push(input logic w, input logic [4:0] a, input logic [XLEN-1:0] d,
                        input logic lr, input logic dr);
        sb.push_back('{we: w, addr: a, dat: d, ld_rdy: lr, dbg_rdy: dr});
    endtask

    task automatic drive_idle();
        alu_we = 0; alu_rd = 0; alu_dat = 0;
        ld_valid = 0; ld_rd = 0; ld_dat = 0;
        dbg_valid = 0; dbg_rd = 0; dbg_dat = 0;
        ld_issue = 0; ld_issue_rd = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({we, ld_ready, dbg_ready, busy, stall} !== 5'b00011) begin
            failures++;
            $display("FAIL reset_outputs got we/ldr/dbgr/busy/stall=%b exp 00011",
                     {we, ld_ready, dbg_ready, busy, stall});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 1; a <= 31; a++) push(1'b1, 5'(a), '0, 1'b0, 1'b0);
        for (int a = 1; a <= 31; a++) begin
            @(negedge clk);
            checks++;
            if ({we, busy, stall} !== 3'b111) begin
                failures++;
                $display("FAIL init_cycle_%0d got we/busy/stall=%b exp 111", a, {we, busy, stall});
            end
        end
        @(negedge clk);
        checks++;
        if ({we, busy, stall} !== 3'b000) begin
            failures++;
            $display("FAIL init_done got we/busy/stall=%b exp 000", {we, busy, stall});
        end
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        alu_we = 1;    alu_rd = 5; alu_dat = 32'hAAAA_0000;
        ld_valid = 1;  ld_rd = 6;  ld_dat = 32'h1234;
        dbg_valid = 1; dbg_rd = 7; dbg_dat = 32'h55;
        push(1'b1, 5'd5, 32'hAAAA_0000, 1'b0, 1'b0);
        push(1'b1, 5'd6, 32'h1234, 1'b1, 1'b0);
        push(1'b1, 5'd7, 32'h55, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({ld_ready, dbg_ready} !== 2'b00) begin
            failures++;
            $display("FAIL prio_alu_blocks got ldr/dbgr=%b exp 00", {ld_ready, dbg_ready});
        end
        @(posedge clk); #1;
        alu_we = 0;
        @(negedge clk);
        checks++;
        if (dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_ld_over_dbg got dbgr=%b exp 0", dbg_ready);
        end
        @(posedge clk); #1;
        ld_valid = 0;
        @(negedge clk);
        @(posedge clk); #1;
        dbg_valid = 0;
        @(negedge clk);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle got we=%b exp 0", we);
        end
    endtask

    task automatic test_raw_stall();
        @(posedge clk); #1;
        ld_issue = 1; ld_issue_rd = 10;
        dec_valid = 1; dec_rs1 = 10; dec_rs2 = 0; dec_rd = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL raw_before_issue_edge got stall=%b exp 0", stall);
        end
        @(posedge clk); #1;
        ld_issue = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL raw_rs1_pending got stall=%b exp 1", stall);
        end
        @(posedge clk); #1;
        dec_rs1 = 0; dec_rd = 10;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL waw_rd_pending got stall=%b exp 1", stall);
        end
        @(posedge clk); #1;
        dec_valid = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL no_dec_valid got stall=%b exp 0", stall);
        end
        @(posedge clk); #1;
        dec_valid = 1; dec_rs1 = 10; dec_rd = 0;
        ld_valid = 1; ld_rd = 10; ld_dat = 32'hDEAD;
        push(1'b1, 5'd10, 32'hDEAD, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL raw_accept_cycle got stall=%b exp 1", stall);
        end
        @(posedge clk); #1;
        ld_valid = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL raw_after_accept got stall=%b exp 0", stall);
        end
        @(posedge clk); #1;
        dec_valid = 0;
    endtask

    task automatic test_same_edge();
        @(posedge clk); #1;
        ld_issue = 1; ld_issue_rd = 3;
        @(posedge clk); #1;
        ld_valid = 1; ld_rd = 3; ld_dat = 32'h33;
        dec_valid = 1; dec_rs1 = 0; dec_rs2 = 3; dec_rd = 0;
        push(1'b1, 5'd3, 32'h33, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        ld_issue = 0; ld_valid = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_set_wins got stall=%b exp 1", stall);
        end
        @(posedge clk); #1;
        ld_valid = 1; ld_rd = 3; ld_dat = 32'h44;
        push(1'b1, 5'd3, 32'h44, 1'b1, 1'b0);
        @(posedge clk); #1;
        ld_valid = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_retire got stall=%b exp 0", stall);
        end
        @(posedge clk); #1;
        dec_valid = 0;
    endtask

    task automatic test_x0();
        @(posedge clk); #1;
        ld_valid = 1; ld_rd = 0; ld_dat = 32'hFFFF;
        ld_issue = 1; ld_issue_rd = 0;
        dec_valid = 1; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        push(1'b0, 5'd0, 32'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({we, ld_ready, stall} !== 3'b010) begin
            failures++;
            $display("FAIL x0_load got we/ldr/stall=%b exp 010", {we, ld_ready, stall});
        end
        @(posedge clk); #1;
        ld_valid = 0; ld_issue = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_pending got stall=%b exp 0", stall);
        end
        @(posedge clk); #1;
        dec_valid = 0;
        dbg_valid = 1; dbg_rd = 0; dbg_dat = 32'h77;
        push(1'b0, 5'd0, 32'h77, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({we, dbg_ready} !== 2'b01) begin
            failures++;
            $display("FAIL x0_debug got we/dbgr=%b exp 01", {we, dbg_ready});
        end
        @(posedge clk); #1;
        dbg_valid = 0;
    endtask

    task automatic test_reset_mid_init();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int a = 1; a <= 12; a++) push(1'b1, 5'(a), '0, 1'b0, 1'b0);
        for (int a = 1; a <= 12; a++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checks++;
        if ({we, ld_ready, dbg_ready, busy, stall} !== 5'b00011) begin
            failures++;
            $display("FAIL mid_init_reset got we/ldr/dbgr/busy/stall=%b exp 00011",
                     {we, ld_ready, dbg_ready, busy, stall});
        end
        @(posedge clk); #1;
        rst = 0;
        ld_valid = 1; ld_rd = 9; ld_dat = 32'h99;
        for (int a = 1; a <= 31; a++) push(1'b1, 5'(a), '0, 1'b0, 1'b0);
        push(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        for (int a = 1; a <= 31; a++) begin
            @(negedge clk);
            checks++;
            if ({we, busy, stall, ld_ready} !== 4'b1110) begin
                failures++;
                $display("FAIL restart_cycle_%0d got we/busy/stall/ldr=%b exp 1110",
                         a, {we, busy, stall, ld_ready});
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, ld_ready} !== 2'b01) begin
            failures++;
            $display("FAIL restart_run got busy/ldr=%b exp 01", {busy, ld_ready});
        end
        @(posedge clk); #1;
        ld_valid = 0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_raw_stall();
        test_same_edge();
        test_x0();
        test_reset_mid_init();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_writes got pending_expectations=%0d exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
